// File: rtl/arb_resp_router.sv
// rtl/arb_resp_router.sv - steers in-order target responses back to the requester granted by the arbiter
// Grant indices are queued at accept time; the head index selects which requester sees the response.
module arb_resp_router #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           grant,
    input  logic                       grant_fire,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       rsp_valid,
    input  logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_ready,
    output logic [WIDTH-1:0]           out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic [WIDTH-1:0]           out_ready,
    output logic                       err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] head_idx;
    logic          grant_multi;
    logic          push;
    logic          pop;

    // Descending scan so the lowest set bit wins when several are set.
    always_comb begin
        grant_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    assign grant_multi = (grant & (grant - WIDTH'(1))) != '0;
    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign push        = grant_fire && !full && (grant != '0);
    assign head_idx    = mem[rd_ptr];

    assign out_valid = (rsp_valid && !empty) ? (WIDTH'(1) << head_idx) : '0;
    assign out_data  = rsp_data;
    assign rsp_ready = !empty && out_ready[head_idx];
    assign pop       = rsp_valid && rsp_ready;

    // Entry contents need no reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((grant_fire && (full || (grant == '0) || grant_multi)) ||
                (rsp_valid && empty)) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arb_resp_router.sv
// tb/tb_arb_resp_router.sv - directed and randomized checks of arb_resp_router against a queue model
module tb_arb_resp_router;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  grant;
    logic        gf;
    logic        rv;
    logic [31:0] rdata;
    logic [7:0]  ordy;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        rsp_ready;
    logic [7:0]  out_valid;
    logic [31:0] out_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    int q[$];
    bit m_err;

    arb_resp_router #(.WIDTH(8), .DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .grant(grant), .grant_fire(gf),
        .full(full), .empty(empty), .count(count),
        .rsp_valid(rv), .rsp_data(rdata), .rsp_ready(rsp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(ordy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic drive(input logic r, input logic [7:0] g, input logic f,
                         input logic v, input logic [31:0] d, input logic [7:0] o);
        rst = r; grant = g; gf = f; rv = v; rdata = d; ordy = o;
        #1;
    endtask

    // Advances one clock and updates the model from the inputs held across the edge.
    task automatic tick();
        bit push, pop;
        push = !rst && gf && q.size() < DEPTH && grant != 0;
        pop  = !rst && rv && q.size() > 0 && ordy[q[0]];
        if (!rst && ((gf && (q.size() == DEPTH || grant == 0 || (grant & (grant - 8'd1)) != 0)) ||
                     (rv && q.size() == 0)))
            m_err = 1'b1;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(lowest(grant));
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_grant(input logic [7:0] g);
        drive(0, g, 1, 0, 0, 8'hFF);
        tick();
        drive(0, 0, 0, 0, 0, 8'hFF);
    endtask

    task automatic test_reset();
        drive(1, 8'h01, 1, 1, 32'h55, 8'hFF);
        tick();
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_out_valid got %h want 00", out_valid); end
        checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %b want 0", rsp_ready); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_in_order();
        logic [7:0]  g [3];
        logic [31:0] d [3];
        g[0] = 8'h08; g[1] = 8'h01; g[2] = 8'h80;
        d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) push_grant(g[i]);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL inorder_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, d[i], 8'hFF);
            checks++; if (out_valid !== g[i]) begin errors++; $display("FAIL inorder_valid%0d got %h want %h", i, out_valid, g[i]); end
            checks++; if (out_data !== d[i] || rsp_ready !== 1'b1) begin errors++; $display("FAIL inorder_data%0d got %h/%b want %h/1", i, out_data, rsp_ready, d[i]); end
            tick();
            checks++; if (count !== 3'(2 - i)) begin errors++; $display("FAIL inorder_cnt%0d got %0d want %0d", i, count, 2 - i); end
        end
        checks++; if (empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL inorder_end got empty=%b err=%b want 1/0", empty, err); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_wrap();
        logic [7:0] g [4];
        logic [7:0] exp_v [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            g[i] = 8'd1 << $urandom_range(7, 0);
            push_grant(g[i]);
        end
        checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full_set got full=%b cnt=%0d want 1/4", full, count); end
        push_grant(8'h02);
        checks++; if (count !== 3'd4 || err !== 1'b1) begin errors++; $display("FAIL full_block got cnt=%0d err=%b want 4/1", count, err); end
        drive(0, 0, 0, 1, 32'h1, 8'hFF);
        checks++; if (out_valid !== g[0]) begin errors++; $display("FAIL wrap_pop0 got %h want %h", out_valid, g[0]); end
        tick();
        push_grant(8'h02);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_refill got %0d want 4", count); end
        exp_v[0] = g[1]; exp_v[1] = g[2]; exp_v[2] = g[3]; exp_v[3] = 8'h02;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 32'(i), 8'hFF);
            checks++; if (out_valid !== exp_v[i]) begin errors++; $display("FAIL wrap_route%0d got %h want %h", i, out_valid, exp_v[i]); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", empty); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        push_grant(8'h08);
        push_grant(8'h20);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 32'hBEEF, 8'hF7);
            checks++; if (out_valid !== 8'h08 || rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %h/%b want 08/0", i, out_valid, rsp_ready); end
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL bp_count%0d got %0d want 2", i, count); end
        end
        drive(0, 0, 0, 1, 32'hBEEF, 8'hFF);
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", rsp_ready); end
        tick();
        drive(0, 0, 0, 1, 32'hCAFE, 8'hFF);
        checks++; if (count !== 3'd1 || out_valid !== 8'h20) begin errors++; $display("FAIL bp_next got cnt=%0d v=%h want 1/20", count, out_valid); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_v [2];
        do_reset();
        push_grant(8'h04);
        push_grant(8'h40);
        drive(0, 8'h10, 1, 1, 32'h77, 8'hFF);
        checks++; if (out_valid !== 8'h04) begin errors++; $display("FAIL sim_head got %h want 04", out_valid); end
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL sim_count got %0d want 2", count); end
        exp_v[0] = 8'h40; exp_v[1] = 8'h10;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 32'(i), 8'hFF);
            checks++; if (out_valid !== exp_v[i]) begin errors++; $display("FAIL sim_order%0d got %h want %h", i, out_valid, exp_v[i]); end
            tick();
        end
        checks++; if (err !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL sim_end got err=%b empty=%b want 0/1", err, empty); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_protocol_errors();
        do_reset();
        drive(0, 0, 0, 1, 32'h9, 8'hFF);
        checks++; if (rsp_ready !== 1'b0 || out_valid !== 8'h00) begin errors++; $display("FAIL perr_empty got %b/%h want 0/00", rsp_ready, out_valid); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_empty_err got %b want 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_clear got %b want 0", err); end
        push_grant(8'h06);
        checks++; if (err !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL perr_multi got err=%b cnt=%0d want 1/1", err, count); end
        drive(0, 0, 0, 1, 32'h3, 8'hFF);
        checks++; if (out_valid !== 8'h02) begin errors++; $display("FAIL perr_multi_route got %h want 02", out_valid); end
        tick();
        do_reset();
        drive(0, 8'h01, 1, 1, 32'h4, 8'hFF);
        checks++; if (rsp_ready !== 1'b0) begin errors++; $display("FAIL perr_nobypass got %b want 0", rsp_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL perr_nobypass_state got err=%b cnt=%0d want 1/1", err, count); end
        drive(0, 8'h00, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL perr_zero_grant got %0d want 1", count); end
    endtask

    task automatic test_random();
        logic [7:0]  g;
        logic [7:0]  ev;
        logic        er;
        logic [31:0] d;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(9, 0))
                0:       g = 8'h00;
                1:       g = 8'($urandom);
                default: g = 8'd1 << $urandom_range(7, 0);
            endcase
            d = $urandom;
            drive(($urandom_range(99, 0) == 0), g, ($urandom_range(1, 0) == 1),
                  ($urandom_range(3, 0) != 0), d, 8'($urandom) | 8'($urandom));
            ev = (rv && q.size() > 0) ? (8'd1 << q[0]) : 8'h00;
            er = (q.size() > 0) ? ordy[q[0]] : 1'b0;
            checks++; if (out_valid !== ev || rsp_ready !== er || out_data !== d) begin
                errors++; $display("FAIL rnd_route%0d got %h/%b/%h want %h/%b/%h", n, out_valid, rsp_ready, out_data, ev, er, d);
            end
            tick();
            checks++; if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || err !== m_err) begin
                errors++; $display("FAIL rnd_state%0d got cnt=%0d e=%b f=%b err=%b want cnt=%0d err=%b", n, count, empty, full, err, q.size(), m_err);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        test_reset();
        test_in_order();
        test_full_wrap();
        test_backpressure();
        test_simultaneous();
        test_protocol_errors();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_resp_router.md
# arb_resp_router

Response-return companion to the fixed-priority arbiter. It records the one-hot grant of every accepted request in an in-order tracking FIFO. Each returning response is steered back to the requester that issued it. It sits between the shared downstream target's response channel and the WIDTH requester response ports, mirroring the arbiter on the request side.

## Interface
- WIDTH, 8, number of requesters; must match the arbiter's WIDTH.
- DEPTH, 4, maximum outstanding requests tracked; power of 2, at least 2.
- DATA_W, 32, response payload width.

- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- grant  input  WIDTH  one-hot grant vector from the arbiter.
- grant_fire  input  1  granted request accepted by the target this cycle.
- full  output  1  tracking FIFO holds DEPTH entries; upstream must not assert grant_fire.
- empty  output  1  no outstanding requests.
- count  output  $clog2(DEPTH+1)  number of outstanding requests.
- rsp_valid  input  1  target response valid.
- rsp_data  input  DATA_W  target response payload.
- rsp_ready  output  1  response consumed this cycle.
- out_valid  output  WIDTH  one-hot per-requester response valid.
- out_data  output  DATA_W  response payload, shared by all requesters.
- out_ready  input  WIDTH  per-requester response ready.
- err  output  1  sticky protocol-error flag.

## Operation
- **Storage.** Circular FIFO of DEPTH entries, each $clog2(WIDTH) bits wide, holding an encoded requester index.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count is a separate register; empty = (count == 0) and full = (count == DEPTH), both decoded from count.
- **Push.** Occurs when grant_fire && !full && (grant != 0).
  - Stores the index of the lowest set bit of grant and increments the write pointer.
  - full blocks a push even if a pop happens in the same cycle. There is no combinational path from out_ready to push acceptance.
- **Head.** head_idx = FIFO[rd_ptr].
- **Routing.** Purely combinational pass-through:
  - out_valid = (rsp_valid && !empty) ? (1 << head_idx) : 0
  - out_data = rsp_data
  - rsp_ready = !empty && out_ready[head_idx]
- **Pop.** Occurs when rsp_valid && rsp_ready; increments the read pointer.
- **Count update.** Push alone: +1. Pop alone: −1. Push and pop in the same cycle: unchanged, with both pointers advancing.
- **err** is set (sticky until rst) on any of:
  - grant_fire while full: no push occurs.
  - grant_fire with grant == 0: no push occurs.
  - grant_fire with more than one grant bit set: the lowest index is pushed anyway.
  - rsp_valid while empty: the response is not consumed and rsp_ready stays 0.
- **Response ordering.** Responses return in grant order; the target must be in-order.
- **Held responses.** A response held by a deasserted out_ready stalls the target: rsp_ready stays 0 and the head is not popped. Later entries wait behind it (head-of-line blocking by design).

## Timing
- **Reset** (synchronous, with rst high at the clk edge):
  - count = 0, pointers = 0, empty = 1, full = 0, err = 0.
  - Consequently out_valid = 0 and rsp_ready = 0.
  - FIFO contents are don't-care.
- **Reset mid-operation** discards all outstanding entries. Responses still in flight afterwards flag err.
- **Push latency.** A push at edge N is visible at the head from cycle N+1. A response in the same cycle as its own grant_fire is not bypassed: it sees empty and flags err.
- **Response path latency.** Zero cycles. out_valid, out_data and rsp_ready follow rsp_valid, rsp_data and out_ready combinationally within the cycle.
- **Flag latency.** full, empty and count reflect the registered state and change only at clk edges. err asserts the cycle after the offending event.
- **Wrap-around.** Pointers roll from DEPTH−1 to 0 with no bubble. Continuous push/pop at count = 1 sustains one response per cycle.

## Test plan
- **Reset values.** Assert rst for 2 cycles with rsp_valid = 1 and out_ready = all-ones → count = 0, empty = 1, full = 0, err = 0, out_valid = 0, rsp_ready = 0.
- **In-order routing.**
  - Stimulus: fire grants 0x08, 0x01, 0x80 on consecutive cycles, then 3 responses with data 0xA, 0xB, 0xC and out_ready = 0xFF.
  - Required: out_valid = 0x08 / 0x01 / 0x80 with the matching data; count goes 3 → 0 and empty = 1.
- **Full and wrap.**
  - Stimulus: with DEPTH = 4, fire 4 grants → full = 1. Fire a 5th grant with 0x02 → no push, err = 1.
  - Then pop one and push 0x02 again → the 4th pointer position wraps to 0, and the next 4 responses route as 0x?, 0x?, 0x?, 0x02 in order.
- **Backpressure.**
  - Stimulus: the head is requester 3 and out_ready = 0xF7.
  - Required: out_valid = 0x08 and rsp_ready = 0 for 5 cycles with count held. Raising out_ready[3] pops the head within the same cycle.
- **Simultaneous push and pop.** At count = 2, fire grant 0x10 and consume a response in the same cycle → count stays 2; the pushed index emerges after the remaining entry.
- **Protocol errors.**
  - Response while empty → rsp_ready = 0 and err = 1.
  - After reset, fire grant 0x06 → err = 1, index 1 pushed, and the next response routes to out_valid = 0x02.
